// File: rtl/posit_pkg.sv
// Shared posit (es = 2) constants and types for the multi-precision pack pipeline.
package posit_pkg;

  typedef enum logic [1:0] {
    PRE_P8   = 2'b00,
    PRE_P16  = 2'b01,
    PRE_P32  = 2'b10,
    PRE_RSVD = 2'b11
  } pre_e;

  localparam int ES = 2;

  localparam logic signed [7:0] MAXSCALE_P8  = 8'sd24;
  localparam logic signed [7:0] MAXSCALE_P16 = 8'sd56;
  localparam logic signed [7:0] MAXSCALE_P32 = 8'sd120;

  localparam logic [31:0] NAR_P8  = 32'h0000_0080;
  localparam logic [31:0] NAR_P16 = 32'h0000_8000;
  localparam logic [31:0] NAR_P32 = 32'h8000_0000;

  // Lane state held between the assembly stage and the rounding stage.
  typedef struct packed {
    pre_e        width;
    logic        sign;
    logic        zero;
    logic        nar;
    logic        sat_max;
    logic        sat_min;
    logic        guard;
    logic        sticky;
    logic [30:0] body;
  } lane_s1_t;

  function automatic pre_e norm_pre(input logic [1:0] p);
    return (p == PRE_RSVD) ? PRE_P32 : pre_e'(p);
  endfunction

  function automatic logic signed [7:0] max_scale(input pre_e p);
    case (p)
      PRE_P8:  return MAXSCALE_P8;
      PRE_P16: return MAXSCALE_P16;
      default: return MAXSCALE_P32;
    endcase
  endfunction

  // Largest n-1 bit body, i.e. maxpos without its sign bit.
  function automatic logic [30:0] max_body(input pre_e p);
    case (p)
      PRE_P8:  return 31'h0000_007F;
      PRE_P16: return 31'h0000_7FFF;
      default: return 31'h7FFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/posit_lane_enc.sv
// Single-lane posit encoder: regime/shift/guard extraction registered, then round/complement.
// POSIT_PACK_SATCNT_EN adds the per-lane clamp flag used by the saturation counter.
module posit_lane_enc
  import posit_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  pre_e        width,
  input  logic        sign,
  input  logic [7:0]  scale,
  input  logic [27:0] frac,
  input  logic        sticky,
  input  logic        zero,
  input  logic        nar,
  output logic [31:0] word
`ifdef POSIT_PACK_SATCNT_EN
  ,
  output logic        sat
`endif
);

  lane_s1_t s1_d, s1_q;

  logic signed [7:0]  scale_s;
  logic        [5:0]  r;
  logic        [4:0]  sh;
  logic signed [63:0] x, y;

  // Seeding {lead, e, frac} and arithmetic-shifting replicates the regime run bit.
  always_comb begin
    // NOTE: every field gets a default first so no path can infer a latch.
    s1_d    = '0;
    scale_s = signed'(scale);
    r       = 6'(scale_s >>> ES);
    sh      = r[4:0] ^ {5{r[5]}};
    x       = {(r[5] ? 2'b01 : 2'b10), scale[ES-1:0], frac, 32'd0};
    y       = x >>> sh;

    s1_d.width   = width;
    s1_d.sign    = sign;
    s1_d.zero    = zero;
    s1_d.nar     = nar;
    s1_d.sat_max = scale_s > max_scale(width);
    s1_d.sat_min = scale_s < -max_scale(width);
    case (width)
      PRE_P8: begin
        s1_d.body   = {24'd0, y[63:57]};
        s1_d.guard  = y[56];
        s1_d.sticky = sticky | (|y[55:0]);
      end
      PRE_P16: begin
        s1_d.body   = {16'd0, y[63:49]};
        s1_d.guard  = y[48];
        s1_d.sticky = sticky | (|y[47:0]);
      end
      default: begin
        s1_d.body   = y[63:33];
        s1_d.guard  = y[32];
        s1_d.sticky = sticky | (|y[31:0]);
      end
    endcase
  end

  // NOTE: pure datapath flops carry no reset; the stage valid in the top qualifies them.
  always_ff @(posedge clk) begin
    if (load) s1_q <= s1_d;
  end

  logic [30:0] maxb, rbody;
  logic [31:0] pos, mag, mask, nar_pat;
  logic        inc;

  always_comb begin
    maxb  = max_body(s1_q.width);
    inc   = s1_q.guard & (s1_q.sticky | s1_q.body[0]) & (s1_q.body != maxb);
    if (s1_q.sat_max)      rbody = maxb;
    else if (s1_q.sat_min) rbody = 31'd1;
    else                   rbody = s1_q.body + 31'(inc);
    pos = {1'b0, rbody};
    mag = s1_q.sign ? -pos : pos;
    case (s1_q.width)
      PRE_P8:  begin mask = 32'h0000_00FF; nar_pat = NAR_P8;  end
      PRE_P16: begin mask = 32'h0000_FFFF; nar_pat = NAR_P16; end
      default: begin mask = 32'hFFFF_FFFF; nar_pat = NAR_P32; end
    endcase
    if (s1_q.nar)       word = nar_pat;
    else if (s1_q.zero) word = 32'd0;
    else                word = mag & mask;
  end

`ifdef POSIT_PACK_SATCNT_EN
  assign sat = (s1_q.sat_max | s1_q.sat_min) & ~s1_q.zero & ~s1_q.nar;
`endif

endmodule

// File: rtl/posit_pack_pipe.sv
// Two-stage 4xp8 / 2xp16 / 1xp32 posit (es = 2) encoder with valid/ready handshake.
// POSIT_PACK_SATCNT_EN adds the sat_cnt clamp counter port.
module posit_pack_pipe
  import posit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_pre,
  input  logic [3:0]  in_sign,
  input  logic [31:0] in_scale,
  input  logic [27:0] in_frac,
  input  logic [3:0]  in_sticky,
  input  logic [3:0]  in_zero,
  input  logic [3:0]  in_nar,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [1:0]  out_pre
`ifdef POSIT_PACK_SATCNT_EN
  ,
  output logic [15:0] sat_cnt
`endif
);

  pre_e             in_pre_n, s1_pre_n;
  logic [3:0][27:0] lane_frac;
  logic [3:0][31:0] lane_word;
  logic             s1_load, s2_load;
  logic             s1_valid_d, s1_valid_q, out_valid_d, out_valid_q;
  logic [1:0]       s1_pre_d, s1_pre_q, out_pre_d, out_pre_q;
  logic [31:0]      merged, out_d, out_q;

  assign in_pre_n = norm_pre(in_pre);
  assign s1_pre_n = norm_pre(s1_pre_q);

  // Align each lane's fraction field to the MSB of the 28-bit lane fraction.
  always_comb begin
    lane_frac = '0;
    for (int i = 0; i < 4; i++) begin
      case (in_pre_n)
        PRE_P8:  lane_frac[i] = {in_frac[7*i +: 7], 21'd0};
        PRE_P16: lane_frac[i] = {in_frac[14*(i%2) +: 14], 14'd0};
        default: lane_frac[i] = in_frac;
      endcase
    end
  end

`ifdef POSIT_PACK_SATCNT_EN
  logic [3:0]  lane_sat, act_mask;
  logic [2:0]  sat_lanes_d, sat_lanes_q;
  logic [15:0] sat_cnt_d, sat_cnt_q;
  logic [16:0] sat_sum;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_lane
    posit_lane_enc u_enc (
      .clk    (clk),
      .load   (s1_load),
      .width  (in_pre_n),
      .sign   (in_sign[g]),
      .scale  (in_scale[8*g +: 8]),
      .frac   (lane_frac[g]),
      .sticky (in_sticky[g]),
      .zero   (in_zero[g]),
      .nar    (in_nar[g]),
      .word   (lane_word[g])
`ifdef POSIT_PACK_SATCNT_EN
      ,
      .sat    (lane_sat[g])
`endif
    );
  end

  always_comb begin
    s2_load     = !out_valid_q || out_ready;
    s1_load     = !s1_valid_q || s2_load;
    s1_valid_d  = s1_load ? in_valid : s1_valid_q;
    s1_pre_d    = s1_load ? in_pre : s1_pre_q;
    out_valid_d = s2_load ? s1_valid_q : out_valid_q;

    case (s1_pre_n)
      PRE_P8:  merged = {lane_word[3][7:0], lane_word[2][7:0],
                         lane_word[1][7:0], lane_word[0][7:0]};
      PRE_P16: merged = {lane_word[1][15:0], lane_word[0][15:0]};
      default: merged = lane_word[0];
    endcase

    // Bubbles pass through the valid only; the last word stays on out.
    out_d     = (s2_load && s1_valid_q) ? merged : out_q;
    out_pre_d = (s2_load && s1_valid_q) ? s1_pre_q : out_pre_q;
  end

`ifdef POSIT_PACK_SATCNT_EN
  always_comb begin
    case (s1_pre_n)
      PRE_P8:  act_mask = 4'b1111;
      PRE_P16: act_mask = 4'b0011;
      default: act_mask = 4'b0001;
    endcase
    sat_lanes_d = (s2_load && s1_valid_q) ? 3'($countones(lane_sat & act_mask)) : sat_lanes_q;
    sat_sum     = {1'b0, sat_cnt_q} + 17'(sat_lanes_q);
    sat_cnt_d   = sat_cnt_q;
    if (out_valid_q && out_ready) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_lanes_q <= '0;
      sat_cnt_q   <= '0;
    end else begin
      sat_lanes_q <= sat_lanes_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_pre_q    <= 2'b00;
      out_valid_q <= 1'b0;
      out_pre_q   <= 2'b00;
      out_q       <= 32'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_pre_q    <= s1_pre_d;
      out_valid_q <= out_valid_d;
      out_pre_q   <= out_pre_d;
      out_q       <= out_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_pre   = out_pre_q;

endmodule

// File: tb/tb_posit_pack_pipe.sv
// Scoreboard bench for posit_pack_pipe: directed vectors with hand-computed posit words.
module tb_posit_pack_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_pre;
  logic [3:0]  in_sign, in_sticky, in_zero, in_nar;
  logic [31:0] in_scale;
  logic [27:0] in_frac;
  logic        out_valid, out_ready;
  logic [31:0] out;
  logic [1:0]  out_pre;
`ifdef POSIT_PACK_SATCNT_EN
  logic [15:0] sat_cnt;
`endif

  always #5 clk = ~clk;

  posit_pack_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pre    (in_pre),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_pre   (out_pre)
`ifdef POSIT_PACK_SATCNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  pre;
    logic [31:0] word;
    int          sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests   = 0;
  int   fails   = 0;
  int   exp_sat = 0;
  int   rdy_mode = 0;
  int   rdy_idx  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // out_ready: 0 = always 1, 1 = repeating 1,0,0,1, 2 = held low.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin
        out_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
        rdy_idx++;
      end
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  logic        prev_stall = 1'b0;
  logic [31:0] prev_out;
  logic [1:0]  prev_pre;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {29'd0, out_valid, out_pre, out}, {29'd0, 1'b1, prev_pre, prev_out});
        if (!in_ready)
          check("in_ready_low_only_full", {62'd0, out_valid, out_ready}, 64'd2);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got %08h expected no word", out);
          end else begin
            mon_e = sb.pop_front();
            check("word", {30'd0, out_pre, out}, {30'd0, mon_e.pre, mon_e.word});
            exp_sat += mon_e.sat;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = out;
        prev_pre   = out_pre;
      end
    end
  end

  task automatic send(input logic [1:0] pre, input logic [3:0] sg, input logic [31:0] sc,
                      input logic [27:0] fr, input logic [3:0] st, input logic [3:0] zr,
                      input logic [3:0] nr, input logic [31:0] exp_w, input int exp_s);
    exp_t e;
    bit   done = 1'b0;
    in_pre = pre; in_sign = sg; in_scale = sc; in_frac = fr;
    in_sticky = st; in_zero = zr; in_nar = nr;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.pre = pre; e.word = exp_w; e.sat = exp_s;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int t = 0; t < 300 && !idle; t++) begin
      @(posedge clk);
      #1;
      idle = (sb.size() == 0) && !out_valid;
    end
    if (!idle) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d words pending, expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [27:0] FRAC_RND = {7'b0011000, 7'b0001000, 7'b0001000, 7'b0001000};

  initial begin
    exp_t e;
    rst_n = 1'b0; in_valid = 1'b0; in_pre = 2'b00; in_sign = '0; in_scale = '0;
    in_frac = '0; in_sticky = '0; in_zero = '0; in_nar = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out_pre", out_pre, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef POSIT_PACK_SATCNT_EN
    check("rst_sat_cnt", sat_cnt, 0);
`endif

    // Latency: accepted at one edge, visible after the second.
    @(posedge clk);
    #1;
    in_pre = 2'b00; in_sign = '0; in_scale = '0; in_frac = '0;
    in_sticky = '0; in_zero = '0; in_nar = '0; in_valid = 1'b1;
    e.pre = 2'b00; e.word = 32'h4040_4040; e.sat = 0;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("latency_cycle1", out_valid, 0);
    @(posedge clk);
    #1 check("latency_cycle2", out_valid, 1);
    wait_idle();

    // p8 basics, rounding, saturation and its boundary.
    send(2'b00, 4'b0100, 32'h0400_0100, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'h60C0_4840, 0);
    send(2'b00, 4'b0100, 32'h0000_0000, FRAC_RND, 4'b0110, 4'b0000, 4'b0000, 32'h42BF_4140, 0);
    send(2'b00, 4'b0000, 32'h0000_E21E, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'h4040_017F, 2);
    send(2'b00, 4'b0100, 32'h00E8_E818, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'h40FF_017F, 0);
    // p32 saturation and plain values; upper scale bytes are unused lanes.
    send(2'b10, 4'b0000, 32'h0000_0079, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'h7FFF_FFFF, 1);
    send(2'b10, 4'b0000, 32'h0000_0087, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0001, 1);
    send(2'b10, 4'b0000, 32'h0000_0000, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'h4000_0000, 0);
    send(2'b10, 4'b0000, 32'h0000_0078, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'h7FFF_FFFF, 0);
    // p16 specials with junk in unused lanes, negative lane, saturation both ways.
    send(2'b01, 4'b0000, 32'h0000_0000, 28'd0, 4'b0000, 4'b0011, 4'b1101, 32'h0000_8000, 0);
    send(2'b01, 4'b0010, 32'h7F7F_0100, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'hB800_4000, 0);
    send(2'b01, 4'b0010, 32'h0000_C739, 28'd0, 4'b0000, 4'b0000, 4'b0000, 32'hFFFF_7FFF, 2);
    wait_idle();

    // Backpressure: alternating p8/p32 while out_ready runs 1,0,0,1.
    rdy_mode = 1;
    send(2'b00, 4'b0000, 32'h0000_0000, 28'd0,          4'b0, 4'b0, 4'b0, 32'h4040_4040, 0);
    send(2'b10, 4'b0000, 32'h0000_0000, 28'h800_0000,   4'b0, 4'b0, 4'b0, 32'h4400_0000, 0);
    send(2'b00, 4'b0100, 32'h0400_0100, 28'd0,          4'b0, 4'b0, 4'b0, 32'h60C0_4840, 0);
    send(2'b10, 4'b0000, 32'h7F7F_7F01, 28'd0,          4'b0, 4'b0, 4'b0, 32'h4800_0000, 0);
    send(2'b00, 4'b0000, 32'hFCFC_FCFC, 28'd0,          4'b0, 4'b0, 4'b0, 32'h2020_2020, 0);
    send(2'b10, 4'b0001, 32'h0000_00FC, 28'd0,          4'b0, 4'b0, 4'b0, 32'hE000_0000, 0);
    rdy_mode = 0;
    wait_idle();
`ifdef POSIT_PACK_SATCNT_EN
    check("sat_cnt_total", sat_cnt, exp_sat);
`endif

    // Reset with both stages full and the output stalled.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(2'b00, 4'b0000, 32'h0000_0000, 28'd0, 4'b0, 4'b0, 4'b0, 32'h4040_4040, 0);
    send(2'b10, 4'b0000, 32'h0000_0000, 28'd0, 4'b0, 4'b0, 4'b0, 32'h4000_0000, 0);
    check("full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
    exp_sat = 0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_in_ready", in_ready, 1);
`ifdef POSIT_PACK_SATCNT_EN
    check("midrst_sat_cnt", sat_cnt, 0);
`endif
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;
    send(2'b01, 4'b0010, 32'h0000_0100, 28'd0, 4'b0, 4'b0, 4'b0, 32'hB800_4000, 0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/posit_pack_pipe.md
# posit_pack_pipe

Pipelined multi-precision posit encoder (es = 2) with valid/ready handshake. It converts per-lane unpacked fields (sign, scale, fraction, sticky, zero/NaR flags) into packed posit words in 4×posit8, 2×posit16 or 1×posit32 SIMD modes. It is the inverse of the posit field extractor and sits at the result end of the fused multiply-add datapath, or anywhere an unpacked value must be written back as a posit.

## Interface
- No parameters; widths are fixed by the 32-bit SIMD word.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_pre  in  2  precision: 00 = 4×p8, 01 = 2×p16, 10 = 1×p32, 11 = reserved (treated as 10).
- in_sign  in  4  lane sign; bit i = lane i.
- in_scale  in  32  signed 8-bit scale (2^scale) per lane, lane i at [8i+7:8i].
- in_frac  in  28  fraction, hidden bit excluded, MSB-aligned. p8 lane i at [7i+6:7i]; p16 lane i at [14i+13:14i]; p32 at [27:0].
- in_sticky  in  4  OR of discarded lower bits, per lane.
- in_zero  in  4  lane is zero.
- in_nar  in  4  lane is NaR.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts.
- out  out  32  packed posits. p8 lane i at [8i+7:8i]; p16 lane i at [16i+15:16i].
- out_pre  out  2  precision carried with the word.
- sat_cnt  out  16  present only with POSIT_PACK_SATCNT_EN.

## Operation
- Only lanes valid for the current in_pre are used; unused lane inputs are ignored.
- Per lane, scale k = 4r + e with e = scale[1:0] and r = scale >>> 2.
  - Regime for r ≥ 0 is r+1 ones then a zero; for r < 0 it is −r zeros then a one.
  - The body is regime, e, frac, truncated to n−1 bits.
- Rounding is round-to-nearest-even.
  - Guard is the first dropped bit.
  - Sticky is the OR of the remaining dropped bits and in_sticky.
  - A carry into the regime is legal (it encodes the next value).
- Saturation:
  - scale > maxscale (p8 24, p16 56, p32 120) gives maxpos.
  - scale < −maxscale, or a nonzero value that rounds to 0, gives minpos.
  - Rounding never exceeds maxpos.
- Negative lanes: the n-bit word is the two's complement of the positive encoding.
- Priority: in_nar over in_zero over everything else. NaR gives 0x80 / 0x8000 / 0x80000000 per lane; zero gives all zeros.

## Timing
- Two register stages:
  - S1: regime/exponent assembly, shift, guard/sticky extraction, saturation detect.
  - S2: rounding increment, two's complement, lane merge.
- Latency is exactly 2 cycles from an accepted beat to out_valid when not stalled.
- Throughput is 1 beat/cycle.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
  - The pipeline advances stage-wise: S2 loads when S2 is empty or out_ready; S1 loads when S1 is empty or S2 loads.
  - in_ready = !s1_valid || s2 can load. It is combinational from out_ready and state only, never from in_valid.
  - Bubbles collapse.
  - While out_valid && !out_ready, out and out_pre hold stable.
- in_pre is captured per beat, so precision may change every beat with no drain.
- Reset (rst_n = 0 at a clk edge) clears both stage valids, including mid-stream.
  - After reset: out_valid = 0, out = 0, out_pre = 00, sat_cnt = 0.
  - in_ready = 1 in the first cycle after reset.

## Configuration
- POSIT_PACK_SATCNT_EN defined:
  - Adds the sat_cnt port.
  - sat_cnt increments on every output transfer by the number of lanes clamped to maxpos or minpos in that word, excluding zero/NaR lanes.
  - It saturates at 0xFFFF.
- Undefined: the port and counter are absent; datapath behaviour is identical.

## Structure
- Shared package posit_pkg holds:
  - precision encodings (PRE_P8 / PRE_P16 / PRE_P32)
  - es = 2
  - per-precision maxscale constants
  - NaR patterns
- One sub-module, posit_lane_enc: single-lane regime/shift/round/complement for a width selected by port. It is instantiated 4× with lane widths fused by precision (lanes 0–3 in p8, 0–1 in p16, 0 in p32).

## Test plan
- p8, all four lanes {sign 0, scale 0, frac 0} → out 0x40404040 after 2 cycles. Lane 1 with scale 1 → byte 0x48; lane 2 with sign 1 → byte 0xC0; lane 3 with scale 4 → byte 0x60.
- p8 rounding: scale 0, frac 7'b0001000, sticky 0 → 0x40 (tie to even). Same with sticky 1 → 0x41.
- Saturation, p8: scale 30 → 0x7F; scale −30 → 0x01. p32 scale 121 → 0x7FFFFFFF. With POSIT_PACK_SATCNT_EN, sat_cnt increments by 2 for the two p8 lanes.
- Specials: p16 lane 0 in_nar with in_zero also set → 0x8000; lane 1 in_zero → 0x0000. p32 scale 0, frac 0 → 0x40000000.
- Backpressure: stream 6 beats alternating in_pre p8/p32 while out_ready toggles 1,0,0,1…
  - All 6 words emerge in order with matching out_pre.
  - out stays stable while stalled.
  - in_ready drops only when both stages are full.
- Reset mid-stream: assert rst_n = 0 with both stages full → next cycle out_valid = 0, out = 0, in_ready = 1; no stale word appears afterwards.
